// File: rtl/mips_bus_arbiter.sv
// Purpose: arbitrates NUM_PORTS request channels onto one wait-stated memory bus (optional ROUND_ROBIN_EN macro selects round-robin, else fixed priority).
// Latency: 3 cycles minimum per transaction (accept, bus cycle, response), plus one cycle per waitrequest-high cycle.
// Backpressure: requests are accepted only while idle; waitrequest stalls the bus cycle with all bus outputs held stable.
module mips_bus_arbiter #(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    localparam int BE_WIDTH  = DATA_WIDTH / 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_PORTS-1:0]             req_valid,
    input  logic [NUM_PORTS-1:0]             req_write,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_address,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  req_writedata,
    input  logic [NUM_PORTS*BE_WIDTH-1:0]    req_byteenable,
    output logic [NUM_PORTS-1:0]             req_ready,
    output logic [NUM_PORTS-1:0]             resp_valid,
    output logic [DATA_WIDTH-1:0]            resp_readdata,
    output logic [ADDR_WIDTH-1:0]            address,
    output logic                             read,
    output logic                             write,
    output logic [DATA_WIDTH-1:0]            writedata,
    output logic [BE_WIDTH-1:0]              byteenable,
    input  logic                             waitrequest,
    input  logic [DATA_WIDTH-1:0]            readdata,
    output logic                             busy
);

    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t                 state_q;
    logic [PW-1:0]          gnt_q;
    logic                   read_q;
    logic                   write_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [DATA_WIDTH-1:0]  wdata_q;
    logic [BE_WIDTH-1:0]    be_q;
    logic [DATA_WIDTH-1:0]  rdata_q;
    logic [NUM_PORTS-1:0]   resp_vld_q;
`ifdef ROUND_ROBIN_EN
    logic [PW-1:0]          ptr_q;
`endif

    logic                   any_vld;
    logic [PW-1:0]          gnt_idx;

    // Pick the port to serve next from the currently valid requests.
    always_comb begin
        any_vld = |req_valid;
        gnt_idx = '0;
`ifdef ROUND_ROBIN_EN
        // Walk downward in distance so the nearest port after the pointer wins last.
        for (int k = NUM_PORTS; k >= 1; k--) begin
            if (req_valid[(int'(ptr_q) + k) % NUM_PORTS]) begin
                gnt_idx = PW'((int'(ptr_q) + k) % NUM_PORTS);
            end
        end
`else
        // Walk downward so the lowest-indexed valid port wins last.
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                gnt_idx = PW'(i);
            end
        end
`endif
    end

    assign req_ready     = (state_q == S_IDLE && any_vld) ? (NUM_PORTS'(1) << gnt_idx) : '0;
    assign resp_valid    = resp_vld_q;
    assign resp_readdata = rdata_q;
    assign address       = addr_q;
    assign writedata     = wdata_q;
    assign byteenable    = be_q;
    assign read          = read_q;
    assign write         = write_q;
    assign busy          = (state_q != S_IDLE);

    // Transaction FSM: accept in IDLE, run the bus cycle in ISSUE, report in RESP.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            gnt_q      <= '0;
            read_q     <= 1'b0;
            write_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            rdata_q    <= '0;
            resp_vld_q <= '0;
`ifdef ROUND_ROBIN_EN
            ptr_q      <= PW'(NUM_PORTS - 1);
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (any_vld) begin
                        gnt_q   <= gnt_idx;
                        addr_q  <= req_address[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
                        wdata_q <= req_writedata[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
                        be_q    <= req_byteenable[gnt_idx*BE_WIDTH +: BE_WIDTH];
                        read_q  <= ~req_write[gnt_idx];
                        write_q <= req_write[gnt_idx];
`ifdef ROUND_ROBIN_EN
                        ptr_q   <= gnt_idx;
`endif
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // Bus outputs stay frozen until the slave drops waitrequest.
                    if (!waitrequest) begin
                        if (read_q) begin
                            rdata_q <= readdata;
                        end
                        read_q     <= 1'b0;
                        write_q    <= 1'b0;
                        resp_vld_q <= NUM_PORTS'(1) << gnt_q;
                        state_q    <= S_RESP;
                    end
                end
                S_RESP: begin
                    resp_vld_q <= '0;
                    state_q    <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Self-checking bench for mips_bus_arbiter: directed scenarios plus randomized traffic.
// A transaction-level model predicts every output each cycle; directed steps pin literal values.
// Inputs change on the falling edge; outputs are sampled shortly after it.
module tb_mips_bus_arbiter;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_write;
    logic [N*AW-1:0]   req_address;
    logic [N*DW-1:0]   req_writedata;
    logic [N*BW-1:0]   req_byteenable;
    logic [N-1:0]      req_ready;
    logic [N-1:0]      resp_valid;
    logic [DW-1:0]     resp_readdata;
    logic [AW-1:0]     address;
    logic              read;
    logic              write;
    logic [DW-1:0]     writedata;
    logic [BW-1:0]     byteenable;
    logic              waitrequest;
    logic [DW-1:0]     readdata;
    logic              busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mips_bus_arbiter #(.NUM_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_write      (req_write),
        .req_address    (req_address),
        .req_writedata  (req_writedata),
        .req_byteenable (req_byteenable),
        .req_ready      (req_ready),
        .resp_valid     (resp_valid),
        .resp_readdata  (resp_readdata),
        .address        (address),
        .read           (read),
        .write          (write),
        .writedata      (writedata),
        .byteenable     (byteenable),
        .waitrequest    (waitrequest),
        .readdata       (readdata),
        .busy           (busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // m_phase: 0 = free, 1 = transfer on the bus, 2 = reporting completion
    int            m_phase;
    int            m_port;
    bit            m_wr;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [BW-1:0] m_be;
    logic [DW-1:0] m_rdata;
    int            m_last;

    function automatic int pick(input logic [N-1:0] v);
`ifdef ROUND_ROBIN_EN
        for (int k = 1; k <= N; k++) begin
            if (v[(m_last + k) % N]) return (m_last + k) % N;
        end
`else
        for (int i = 0; i < N; i++) begin
            if (v[i]) return i;
        end
`endif
        return 0;
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_port  = 0;
        m_wr    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        m_be    = '0;
        m_rdata = '0;
        m_last  = N - 1;
    endtask

    logic [N-1:0] exp_ready;
    logic [N-1:0] exp_resp;
    int           g;

    // Compare every output against the model each cycle, then advance the model.
    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            #1;
            if (reset !== 1'b1) model_reset();
            exp_ready = '0;
            if (m_phase == 0 && req_valid != '0) exp_ready = N'(1) << pick(req_valid);
            exp_resp = (m_phase == 2) ? (N'(1) << m_port) : '0;
            chk("m_req_ready", 64'(req_ready), 64'(exp_ready));
            chk("m_resp_valid", 64'(resp_valid), 64'(exp_resp));
            chk("m_resp_readdata", 64'(resp_readdata), 64'(m_rdata));
            chk("m_read", 64'(read), 64'(m_phase == 1 && !m_wr));
            chk("m_write", 64'(write), 64'(m_phase == 1 && m_wr));
            chk("m_rw_excl", 64'(read & write), 64'(0));
            chk("m_address", 64'(address), 64'(m_addr));
            chk("m_writedata", 64'(writedata), 64'(m_wdata));
            chk("m_byteenable", 64'(byteenable), 64'(m_be));
            chk("m_busy", 64'(busy), 64'(m_phase != 0));
            if (reset === 1'b1) begin
                if (m_phase == 0) begin
                    if (req_valid != '0) begin
                        g       = pick(req_valid);
                        m_port  = g;
                        m_last  = g;
                        m_wr    = req_write[g];
                        m_addr  = req_address[g*AW +: AW];
                        m_wdata = req_writedata[g*DW +: DW];
                        m_be    = req_byteenable[g*BW +: BW];
                        m_phase = 1;
                    end
                end else if (m_phase == 1) begin
                    if (!waitrequest) begin
                        if (!m_wr) m_rdata = readdata;
                        m_phase = 2;
                    end
                end else begin
                    m_phase = 0;
                end
            end
        end
    end

    // ---------------- directed + random stimulus ----------------
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic set_port(input int p, input bit w, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic [BW-1:0] be);
        req_valid                 = N'(1) << p;
        req_write[p]              = w;
        req_address[p*AW +: AW]   = a;
        req_writedata[p*DW +: DW] = d;
        req_byteenable[p*BW +: BW] = be;
    endtask

    int exp_order[4];
    logic [N-1:0] exp_gnt;

    initial begin
`ifdef ROUND_ROBIN_EN
        exp_order = '{0, 1, 0, 1};
`else
        exp_order = '{0, 0, 0, 0};
`endif
        reset          = 1'b0;
        req_valid      = '0;
        req_write      = '0;
        req_address    = '0;
        req_writedata  = '0;
        req_byteenable = '0;
        waitrequest    = 1'b0;
        readdata       = '0;

        // Reset state
        cyc(); cyc();
        #2;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_address", 64'(address), 64'(0));
        chk("rst_rdata", 64'(resp_readdata), 64'(0));
        cyc();
        reset = 1'b1;

        // Single read on port 0
        cyc(); set_port(0, 1'b0, 32'h100, 32'h0, 4'hF); readdata = 32'hDEADBEEF;
        #2; chk("t1_ready", 64'(req_ready), 64'(2'b01));
        cyc(); req_valid = '0;
        #2; chk("t1_read", 64'(read), 64'(1)); chk("t1_addr", 64'(address), 64'(32'h100));
        cyc();
        #2; chk("t1_resp", 64'(resp_valid), 64'(2'b01)); chk("t1_rdata", 64'(resp_readdata), 64'(32'hDEADBEEF));

        // Write on port 1 with three wait states
        cyc(); set_port(1, 1'b1, 32'h200, 32'h12345678, 4'hF); waitrequest = 1'b1;
        #2; chk("t2_ready", 64'(req_ready), 64'(2'b10));
        for (int i = 0; i < 4; i++) begin
            cyc(); req_valid = '0; waitrequest = (i < 3);
            #2;
            chk("t2_write", 64'(write), 64'(1));
            chk("t2_addr", 64'(address), 64'(32'h200));
            chk("t2_wdata", 64'(writedata), 64'(32'h12345678));
        end
        cyc(); waitrequest = 1'b0;
        #2; chk("t2_resp", 64'(resp_valid), 64'(2'b10)); chk("t2_write_off", 64'(write), 64'(0));

        // Both ports requesting continuously
        for (int t = 0; t < 4; t++) begin
            cyc(); req_valid = 2'b11; req_write = 2'b00;
            #2; exp_gnt = N'(1) << exp_order[t];
            chk("t3_grant", 64'(req_ready), 64'(exp_gnt));
            cyc(); cyc();
        end

        // Reset during a stalled read
        cyc(); set_port(0, 1'b0, 32'h280, 32'h0, 4'hF); waitrequest = 1'b1;
        #2; chk("t4_ready", 64'(req_ready), 64'(2'b01));
        cyc(); req_valid = '0;
        #2; chk("t4_read", 64'(read), 64'(1)); chk("t4_busy", 64'(busy), 64'(1));
        cyc(); reset = 1'b0;
        #2;
        chk("t4_rst_read", 64'(read), 64'(0));
        chk("t4_rst_write", 64'(write), 64'(0));
        chk("t4_rst_busy", 64'(busy), 64'(0));
        chk("t4_rst_resp", 64'(resp_valid), 64'(0));
        cyc(); waitrequest = 1'b0;
        #2; chk("t4_no_resp", 64'(resp_valid), 64'(0));
        cyc(); reset = 1'b1; set_port(1, 1'b0, 32'h300, 32'h0, 4'hF); readdata = 32'hCAFEF00D;
        #2; chk("t4b_ready", 64'(req_ready), 64'(2'b10));
        cyc(); req_valid = '0;
        #2; chk("t4b_read", 64'(read), 64'(1)); chk("t4b_addr", 64'(address), 64'(32'h300));
        cyc();
        #2; chk("t4b_resp", 64'(resp_valid), 64'(2'b10)); chk("t4b_rdata", 64'(resp_readdata), 64'(32'hCAFEF00D));

        // Zero-byteenable write, then a read
        cyc(); set_port(0, 1'b1, 32'h400, 32'hA5A5A5A5, 4'h0); readdata = 32'h11111111;
        #2; chk("t5_ready", 64'(req_ready), 64'(2'b01));
        cyc(); req_valid = '0;
        #2; chk("t5_write", 64'(write), 64'(1)); chk("t5_be", 64'(byteenable), 64'(0));
        cyc();
        #2; chk("t5_resp", 64'(resp_valid), 64'(2'b01)); chk("t5_rdata_kept", 64'(resp_readdata), 64'(32'hCAFEF00D));
        cyc(); set_port(0, 1'b0, 32'h404, 32'h0, 4'hF); readdata = 32'h55AA55AA;
        #2; chk("t5b_ready", 64'(req_ready), 64'(2'b01));
        cyc(); req_valid = '0;
        #2; chk("t5b_read", 64'(read), 64'(1)); chk("t5b_rdata_hold", 64'(resp_readdata), 64'(32'hCAFEF00D));
        cyc();
        #2; chk("t5b_resp", 64'(resp_valid), 64'(2'b01)); chk("t5b_rdata", 64'(resp_readdata), 64'(32'h55AA55AA));

        // Randomized traffic, wait states and occasional resets
        for (int i = 0; i < 3000; i++) begin
            cyc();
            req_valid      = N'($urandom_range(0, 3));
            req_write      = N'($urandom);
            req_address    = {$urandom, $urandom};
            req_writedata  = {$urandom, $urandom};
            req_byteenable = (N*BW)'($urandom);
            waitrequest    = ($urandom_range(0, 2) == 0);
            readdata       = $urandom;
            reset          = ($urandom_range(0, 150) != 0);
        end

        cyc();
        reset = 1'b1;
        req_valid = '0;
        cyc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
